// File: rtl/fib_pkg.sv
// Shared types and default widths for the fib_server request/response kernel.
package fib_pkg;

   localparam int unsigned FIB_N_W = 6;
   localparam int unsigned FIB_D_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fib_state_t;

   typedef struct packed {
      logic [FIB_N_W-1:0] n;
      logic [FIB_D_W-1:0] a;
      logic [FIB_D_W-1:0] b;
   } fib_req_t;

endpackage

// File: rtl/fib_req_fifo.sv
// Request FIFO for fib_server; push while full is accepted only alongside a pop.
module fib_req_fifo
   import fib_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = fib_req_t,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  T                 push_data_i,
   input  logic             pop_i,
   output T                 head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_q];

   // Guard against illegal strobes so the pointers can never desynchronise.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

endmodule

// File: rtl/fib_server.sv
// Queued responder evaluating fib(n, a, b) one iteration per cycle, returning
// each result with a w_enable pulse in request order.
module fib_server
   import fib_pkg::*;
#(
   parameter int unsigned N_W   = FIB_N_W,
   parameter int unsigned D_W   = FIB_D_W,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           r_enable,
   input  logic           controlArr,
   input  logic [N_W-1:0] init_n,
   input  logic [D_W-1:0] init_a,
   input  logic [D_W-1:0] init_b,
   output logic           w_enable,
   output logic [D_W-1:0] result,
   output logic           busy,
   output logic           overflow
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [N_W-1:0] n;
      logic [D_W-1:0] a;
      logic [D_W-1:0] b;
   } req_t;

   fib_state_t       state_q, state_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [D_W-1:0]   a_q, a_d;
   logic [D_W-1:0]   b_q, b_d;
   logic [D_W-1:0]   result_q, result_d;
   logic             w_enable_q, w_enable_d;
   logic             busy_q, busy_d;
   logic             overflow_q, overflow_d;

   logic             push;
   logic             pop;
   req_t             push_data;
   req_t             head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] cnt_nxt;

   assign push_data = '{n: init_n, a: init_a, b: init_b};

   fib_req_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   // Next-state: stall freezes FSM and datapath, and holds w_enable in DONE.
   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      a_d        = a_q;
      b_d        = b_q;
      result_d   = result_q;
      w_enable_d = controlArr ? w_enable_q : 1'b0;
      pop        = 1'b0;

      if (!controlArr) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  n_d     = head.n;
                  a_d     = head.a;
                  b_d     = head.b;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (n_q != '0) begin
                  a_d = a_q + b_q;
                  b_d = a_q;
                  n_d = n_q - N_W'(1);
               end else begin
                  result_d   = b_q;
                  w_enable_d = 1'b1;
                  state_d    = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      push       = r_enable && (!fifo_full || pop);
      overflow_d = overflow_q || (r_enable && !push);
      cnt_nxt    = fifo_count + CNT_W'(push) - CNT_W'(pop);
      busy_d     = (state_d != IDLE) || (cnt_nxt != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         n_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         result_q   <= '0;
         w_enable_q <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         a_q        <= a_d;
         b_q        <= b_d;
         result_q   <= result_d;
         w_enable_q <= w_enable_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
      end
   end

   assign w_enable = w_enable_q;
   assign result   = result_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

endmodule
